// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters advanced on pix_clk rising edges, with
// sync, visible-area and line/frame tick outputs all registered alongside x/y.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_clk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hs,
  output logic       vs,
  output logic       active,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);

  logic       pix_q;
  logic [9:0] x_q, y_q;
  logic       hs_q, vs_q, active_q, line_tick_q, frame_tick_q;

  logic       pix_en, h_wrap, v_wrap;
  logic [9:0] x_d, y_d;
  logic       hs_d, vs_d, active_d;

  // Decode from the next counter values so the registered decodes line up
  // with the x/y they describe.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    pix_en   = pix_clk & ~pix_q;
    h_wrap   = (x_q == H_LAST);
    v_wrap   = (y_q == V_LAST);
    x_d      = h_wrap ? 10'd0 : x_q + 10'd1;
    y_d      = y_q;
    if (h_wrap) y_d = v_wrap ? 10'd0 : y_q + 10'd1;
    hs_d     = (x_d >= HS_FIRST && x_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vs_d     = (y_d >= VS_FIRST && y_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    active_d = ({1'b0, x_d} < H_VIS) && ({1'b0, y_d} < V_VIS);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // pix_q resets high so a pix_clk held high across release is not an edge.
      pix_q        <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
      active_q     <= 1'b1;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pix_q        <= pix_clk;
      line_tick_q  <= pix_en & h_wrap;
      frame_tick_q <= pix_en & h_wrap & v_wrap;
      if (pix_en) begin
        x_q      <= x_d;
        y_q      <= y_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        active_q <= active_d;
      end
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign hs         = hs_q;
  assign vs         = vs_q;
  assign active     = active_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule
